// File: rtl/sys1_ram_arb.sv
// sys1_ram_arb: shares the System1 main RAM between the CPU bus and the HPS ioctl download stream.
// Define SYS1_DL_CHECKSUM_EN to add dl_sum, the modulo-256 sum of downloaded bytes written to RAM.
module sys1_ram_arb #(
   parameter int                ADDR_W     = 16,
   parameter int                FIFO_DEPTH = 4,
   parameter int                STARVE_MAX = 4,
   parameter logic [7:0]        DL_INDEX   = 8'd1,
   parameter logic [ADDR_W-1:0] DL_BASE    = 16'h0000
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              cpu_cs,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              cpu_rvalid,
   output logic              cpu_wait,
   output logic              cpu_hold,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   input  logic [7:0]        ram_dout,
`ifdef SYS1_DL_CHECKSUM_EN
   output logic [7:0]        dl_sum,
`endif
   output logic              dl_done,
   output logic              dl_err
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);
   // First download offset that would wrap past the top of RAM.
   localparam logic [25:0] ADDR_LIMIT = (26'd1 << ADDR_W) - 26'(DL_BASE);

   typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN} state_t;

   state_t               state_reg, state_next;
   logic                 dl_prev_reg;
   logic [ADDR_W-1:0]    fifo_addr_mem [FIFO_DEPTH];
   logic [7:0]           fifo_data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]     count_reg, count_next;
   logic [STARVE_W-1:0]  starve_reg, starve_next;
   logic                 cpu_rvalid_reg;
   logic                 dl_done_reg, dl_done_next;
   logic                 dl_err_reg, dl_err_next;

   logic                 fifo_empty, fifo_full;
   logic                 cpu_grant, fifo_grant;
   logic                 dl_start, dl_fall;
   logic                 push_req, in_range, push;
   logic [ADDR_W-1:0]    push_addr;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));

   // Slot decision uses only registered FIFO/counter state plus cpu_cs; no slot is granted in reset.
   assign cpu_grant  = reset_n && cpu_cs && (fifo_empty || starve_reg < STARVE_W'(STARVE_MAX));
   assign fifo_grant = reset_n && !cpu_grant && !fifo_empty;

   assign dl_start  = !dl_prev_reg && ioctl_download && (ioctl_index == DL_INDEX);
   assign dl_fall   = dl_prev_reg && !ioctl_download;
   assign push_req  = (state_reg == ST_LOAD) && ioctl_wr;
   assign in_range  = ({1'b0, ioctl_addr} < ADDR_LIMIT);
   assign push      = push_req && in_range && !fifo_full;
   assign push_addr = DL_BASE + ioctl_addr[ADDR_W-1:0];

   always_comb begin
      state_next   = state_reg;
      dl_done_next = 1'b0;
      dl_err_next  = dl_err_reg;
      case (state_reg)
         ST_RUN: begin
            if (dl_start) begin
               state_next  = ST_LOAD;
               dl_err_next = 1'b0;
            end
         end
         ST_LOAD: begin
            if (push_req && (!in_range || fifo_full)) dl_err_next = 1'b1;
            if (dl_fall) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               state_next   = ST_RUN;
               dl_done_next = 1'b1;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      if (push && !fifo_grant)      count_next = count_reg + CNT_W'(1);
      else if (!push && fifo_grant) count_next = count_reg - CNT_W'(1);

      starve_next = starve_reg;
      if (fifo_empty || fifo_grant)                             starve_next = '0;
      else if (cpu_grant && starve_reg != STARVE_W'(STARVE_MAX)) starve_next = starve_reg + STARVE_W'(1);
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_reg      <= ST_RUN;
         dl_prev_reg    <= 1'b0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         starve_reg     <= '0;
         cpu_rvalid_reg <= 1'b0;
         dl_done_reg    <= 1'b0;
         dl_err_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         dl_prev_reg    <= ioctl_download;
         count_reg      <= count_next;
         starve_reg     <= starve_next;
         cpu_rvalid_reg <= cpu_grant && !cpu_we;
         dl_done_reg    <= dl_done_next;
         dl_err_reg     <= dl_err_next;
         if (push)       wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (fifo_grant) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_addr_mem[wr_ptr_reg] <= push_addr;
         fifo_data_mem[wr_ptr_reg] <= ioctl_dout;
      end
   end

`ifdef SYS1_DL_CHECKSUM_EN
   logic [7:0] sum_reg;
   always_ff @(posedge clk_sys) begin
      if (!reset_n)                           sum_reg <= 8'h00;
      else if (state_reg == ST_RUN && dl_start) sum_reg <= 8'h00;
      else if (fifo_grant)                    sum_reg <= sum_reg + fifo_data_mem[rd_ptr_reg];
   end
   assign dl_sum = sum_reg;
`endif

   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = 8'h00;
      if (cpu_grant) begin
         ram_en   = 1'b1;
         ram_we   = cpu_we;
         ram_addr = cpu_addr;
         ram_din  = cpu_din;
      end else if (fifo_grant) begin
         ram_en   = 1'b1;
         ram_we   = 1'b1;
         ram_addr = fifo_addr_mem[rd_ptr_reg];
         ram_din  = fifo_data_mem[rd_ptr_reg];
      end
   end

   assign cpu_dout   = ram_dout;
   assign cpu_rvalid = cpu_rvalid_reg;
   assign cpu_wait   = cpu_cs && !cpu_grant;
   assign cpu_hold   = (state_reg != ST_RUN);
   assign ioctl_wait = (count_reg >= CNT_W'(FIFO_DEPTH - 1));
   assign dl_done    = dl_done_reg;
   assign dl_err     = dl_err_reg;

endmodule

// File: tb/tb_sys1_ram_arb.sv
// Testbench for sys1_ram_arb: behavioural RAM plus a queue-level model of the download path.
module tb_sys1_ram_arb;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        cpu_cs, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din, cpu_dout;
   logic        cpu_rvalid, cpu_wait, cpu_hold;
   logic        ioctl_download, ioctl_wr, ioctl_wait;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;
   logic        ram_en, ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_din, ram_dout;
   logic        dl_done, dl_err;
`ifdef SYS1_DL_CHECKSUM_EN
   logic [7:0]  dl_sum;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int ram_writes  = 0;
   int done_pulses = 0;

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   always #5 clk_sys = ~clk_sys;

   sys1_ram_arb dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_rvalid(cpu_rvalid), .cpu_wait(cpu_wait), .cpu_hold(cpu_hold),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
`ifdef SYS1_DL_CHECKSUM_EN
      .dl_sum(dl_sum),
`endif
      .dl_done(dl_done), .dl_err(dl_err)
   );

   // Single-port synchronous RAM with one cycle of read latency.
   always @(posedge clk_sys) begin
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_din;
            ram_writes    <= ram_writes + 1;
         end else begin
            ram_dout <= mem[ram_addr];
         end
      end
      if (dl_done) done_pulses <= done_pulses + 1;
   end

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk_sys);
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
      @(negedge clk_sys);
      cpu_cs = 1'b0; cpu_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic wait_done(input int start, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_sys);
         if (done_pulses != start) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (4) @(negedge clk_sys);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
      ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      reset_n = 1'b1;
      @(posedge clk_sys); #1;
      vectors++; if (cpu_hold !== 1'b0)   begin miscompares++; $display("FAIL reset_cpu_hold got %b want 0", cpu_hold); end
      vectors++; if (dl_done !== 1'b0)    begin miscompares++; $display("FAIL reset_dl_done got %b want 0", dl_done); end
      vectors++; if (dl_err !== 1'b0)     begin miscompares++; $display("FAIL reset_dl_err got %b want 0", dl_err); end
      vectors++; if (cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_rvalid got %b want 0", cpu_rvalid); end
      vectors++; if (ioctl_wait !== 1'b0) begin miscompares++; $display("FAIL reset_ioctl_wait got %b want 0", ioctl_wait); end
      vectors++; if ({ram_en, ram_we, ram_addr, ram_din} !== 26'd0)
         begin miscompares++; $display("FAIL reset_ram_outputs got en=%b we=%b a=%h d=%h want all 0", ram_en, ram_we, ram_addr, ram_din); end
      $display("reset: outputs checked after reset release");
   endtask

   task automatic test_cpu_only();
      logic [15:0] a;
      logic [7:0]  d;
      @(negedge clk_sys);
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_din = 8'h5A; #1;
      vectors++; if (cpu_wait !== 1'b0) begin miscompares++; $display("FAIL cpu_wr_wait got %b want 0", cpu_wait); end
      vectors++; if ({ram_en, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 16'h0200, 8'h5A})
         begin miscompares++; $display("FAIL cpu_wr_ram got en=%b we=%b a=%h d=%h want 1 1 0200 5a", ram_en, ram_we, ram_addr, ram_din); end
      ref_mem[16'h0200] = 8'h5A;
      @(negedge clk_sys);
      cpu_we = 1'b0; #1;
      vectors++; if (cpu_wait !== 1'b0) begin miscompares++; $display("FAIL cpu_rd_wait got %b want 0", cpu_wait); end
      @(negedge clk_sys);
      cpu_cs = 1'b0; #1;
      vectors++; if (cpu_rvalid !== 1'b1) begin miscompares++; $display("FAIL cpu_rd_rvalid got %b want 1", cpu_rvalid); end
      vectors++; if (cpu_dout !== 8'h5A)  begin miscompares++; $display("FAIL cpu_rd_dout got %h want 5a", cpu_dout); end
      $display("cpu: write 5a to 0200, read back %h", cpu_dout);
      for (int i = 0; i < 8; i++) begin
         a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
         d = 8'($urandom);
         cpu_write(a, d);
         cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a; #1;
         vectors++; if (cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL cpu_rand_wr_rvalid got %b want 0", cpu_rvalid); end
         @(negedge clk_sys);
         cpu_cs = 1'b0; #1;
         vectors++; if (cpu_rvalid !== 1'b1 || cpu_dout !== ref_mem[a])
            begin miscompares++; $display("FAIL cpu_rand_rd addr %h got rvalid=%b dout=%h want 1 %h", a, cpu_rvalid, cpu_dout, ref_mem[a]); end
         $display("cpu: addr %h wrote %h read %h", a, d, cpu_dout);
      end
   endtask

   task automatic test_download();
      int  start = done_pulses;
      int  i = 0;
      int  guard = 0;
      bit  ok;
      @(negedge clk_sys);
      ioctl_index = 8'd1; ioctl_download = 1'b1; #1;
      vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL dl_hold_before got %b want 0", cpu_hold); end
      @(negedge clk_sys); #1;
      vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL dl_hold_after got %b want 1", cpu_hold); end
      while (i < 8 && guard < 200) begin
         guard++;
         if (!ioctl_wait) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i);
            ref_mem[i] = 8'(i);
            if (i == 7) ioctl_download = 1'b0;
            i++;
         end else begin
            ioctl_wr = 1'b0;
         end
         @(negedge clk_sys);
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      wait_done(start, ok);
      vectors++; if (done_pulses != start + 1) begin miscompares++; $display("FAIL dl_done_count got %0d want 1", done_pulses - start); end
      vectors++; if (dl_err !== 1'b0)   begin miscompares++; $display("FAIL dl_err got %b want 0", dl_err); end
      vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL dl_hold_end got %b want 0", cpu_hold); end
      for (int k = 0; k < 8; k++) begin
         vectors++; if (mem[k] !== ref_mem[k]) begin miscompares++; $display("FAIL dl_ram addr %0d got %h want %h", k, mem[k], ref_mem[k]); end
      end
`ifdef SYS1_DL_CHECKSUM_EN
      vectors++; if (dl_sum !== 8'h1C) begin miscompares++; $display("FAIL dl_sum got %h want 1c", dl_sum); end
`endif
      $display("download: 8 bytes at offset 0, done=%0d err=%b", done_pulses - start, dl_err);
   endtask

   // FIFO is non-empty from cycle 1, so the CPU may take at most STARVE_MAX=4 slots before each FIFO slot.
   task automatic test_starve();
      int  start = done_pulses;
      bit  ok;
      bit  exp_f;
      int  idx;
      @(negedge clk_sys);
      ioctl_index = 8'd1; ioctl_download = 1'b1;
      @(negedge clk_sys);
      cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h9000;
      for (int c = 0; c <= 16; c++) begin
         ioctl_wr = (c < 3);
         ioctl_addr = 25'(16'h0020 + c); ioctl_dout = 8'(8'hA0 + c);
         if (c < 3) ref_mem[16'h0020 + c] = 8'(8'hA0 + c);
         if (c == 3) ioctl_download = 1'b0;
         exp_f = (c >= 5) && (c <= 15) && (c % 5 == 0);
         idx = c / 5 - 1;
         #1;
         vectors++; if (cpu_wait !== exp_f || ram_we !== exp_f)
            begin miscompares++; $display("FAIL starve_slot cycle %0d got wait=%b we=%b want %b", c, cpu_wait, ram_we, exp_f); end
         if (exp_f) begin
            vectors++; if (ram_addr !== 16'(16'h0020 + idx) || ram_din !== 8'(8'hA0 + idx))
               begin miscompares++; $display("FAIL starve_fifo_data cycle %0d got %h/%h want %h/%h", c, ram_addr, ram_din, 16'h0020 + idx, 8'hA0 + idx); end
         end
         @(negedge clk_sys);
      end
      ioctl_wr = 1'b0; cpu_cs = 1'b0;
      wait_done(start, ok);
      vectors++; if (done_pulses != start + 1) begin miscompares++; $display("FAIL starve_done_count got %0d want 1", done_pulses - start); end
      for (int k = 0; k < 3; k++) begin
         vectors++; if (mem[16'h0020 + k] !== ref_mem[16'h0020 + k])
            begin miscompares++; $display("FAIL starve_ram addr %h got %h want %h", 16'h0020 + k, mem[16'h0020 + k], ref_mem[16'h0020 + k]); end
      end
      $display("starve: 3 bytes under continuous cpu_cs");
   endtask

   task automatic test_back_to_back();
      logic [15:0] mq_addr[$];
      logic [7:0]  mq_data[$];
      int  mst = 0;
      int  sent = 0;
      int  guard = 0;
      int  start = done_pulses;
      int  sz;
      bit  cpu_g, fifo_g, ok, saw_wait;
      saw_wait = 1'b0;
      @(negedge clk_sys);
      ioctl_index = 8'd1; ioctl_download = 1'b1;
      @(negedge clk_sys);
      cpu_cs = 1'b1; cpu_we = 1'b0;
      while ((sent < 12 || mq_addr.size() != 0) && guard < 400) begin
         guard++;
         sz = mq_addr.size();
         vectors++; if (ioctl_wait !== (sz >= 3))
            begin miscompares++; $display("FAIL b2b_ioctl_wait count %0d got %b want %b", sz, ioctl_wait, sz >= 3); end
         if (ioctl_wait) saw_wait = 1'b1;
         if (sent < 12 && !ioctl_wait) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(16'h0100 + sent); ioctl_dout = 8'($urandom);
         end else begin
            ioctl_wr = 1'b0;
         end
         if (sent == 12) ioctl_download = 1'b0;
         cpu_addr = 16'h9000 | 16'($urandom_range(0, 255));
         cpu_g  = (sz == 0) || (mst < 4);
         fifo_g = !cpu_g && (sz != 0);
         #1;
         vectors++; if (cpu_wait !== !cpu_g || ram_we !== fifo_g)
            begin miscompares++; $display("FAIL b2b_grant got wait=%b we=%b want %b %b", cpu_wait, ram_we, !cpu_g, fifo_g); end
         if (fifo_g) begin
            vectors++; if (ram_addr !== mq_addr[0] || ram_din !== mq_data[0])
               begin miscompares++; $display("FAIL b2b_fifo_data got %h/%h want %h/%h", ram_addr, ram_din, mq_addr[0], mq_data[0]); end
         end
         @(posedge clk_sys);
         if (sz == 0 || fifo_g) mst = 0;
         else if (cpu_g && mst < 4) mst++;
         if (fifo_g) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
         end
         if (ioctl_wr) begin
            mq_addr.push_back(16'(ioctl_addr));
            mq_data.push_back(ioctl_dout);
            ref_mem[16'(ioctl_addr)] = ioctl_dout;
            sent++;
         end
         @(negedge clk_sys);
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0; cpu_cs = 1'b0;
      vectors++; if (guard >= 400) begin miscompares++; $display("FAIL b2b_timeout sent %0d pending %0d want 12 0", sent, mq_addr.size()); end
      vectors++; if (saw_wait !== 1'b1) begin miscompares++; $display("FAIL b2b_wait_seen got 0 want 1"); end
      wait_done(start, ok);
      vectors++; if (dl_err !== 1'b0) begin miscompares++; $display("FAIL b2b_dl_err got %b want 0", dl_err); end
      for (int k = 0; k < 12; k++) begin
         vectors++; if (mem[16'h0100 + k] !== ref_mem[16'h0100 + k])
            begin miscompares++; $display("FAIL b2b_ram addr %h got %h want %h", 16'h0100 + k, mem[16'h0100 + k], ref_mem[16'h0100 + k]); end
      end
      $display("back_to_back: 12 bytes with cpu saturating, done=%b", ok);
   endtask

   task automatic test_bad_index();
      int start;
      bit ok;
      for (int k = 0; k < 4; k++) cpu_write(16'h0040 + 16'(k), 8'hEE);
      start = done_pulses;
      @(negedge clk_sys);
      ioctl_index = 8'd2; ioctl_download = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_sys);
         ioctl_wr = (c < 4); ioctl_addr = 25'(16'h0040 + c); ioctl_dout = 8'h11; #1;
         vectors++; if (cpu_hold !== 1'b0 || ram_en !== 1'b0)
            begin miscompares++; $display("FAIL idx2_quiet cycle %0d got hold=%b en=%b want 0 0", c, cpu_hold, ram_en); end
      end
      @(negedge clk_sys);
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      repeat (3) @(negedge clk_sys);
      vectors++; if (done_pulses != start) begin miscompares++; $display("FAIL idx2_done got %0d want 0", done_pulses - start); end
      for (int k = 0; k < 4; k++) begin
         vectors++; if (mem[16'h0040 + k] !== ref_mem[16'h0040 + k])
            begin miscompares++; $display("FAIL idx2_ram addr %h got %h want %h", 16'h0040 + k, mem[16'h0040 + k], ref_mem[16'h0040 + k]); end
      end
      $display("bad_index: index 2 download ignored");
      ioctl_index = 8'd1; ioctl_download = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b1; ioctl_addr = 25'h10000; ioctl_dout = 8'h77;
      @(negedge clk_sys);
      ioctl_wr = 1'b0; #1;
      vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL oor_dropped got en=%b want 0", ram_en); end
      @(negedge clk_sys);
      ioctl_download = 1'b0;
      wait_done(start, ok);
      vectors++; if (dl_err !== 1'b1) begin miscompares++; $display("FAIL oor_dl_err got %b want 1", dl_err); end
      vectors++; if (mem[0] !== ref_mem[0]) begin miscompares++; $display("FAIL oor_ram0 got %h want %h", mem[0], ref_mem[0]); end
      $display("bad_index: offset 10000 dropped, dl_err=%b", dl_err);
   endtask

   task automatic test_reset_mid_load();
      int writes;
      cpu_write(16'h3000, 8'hC3);
      cpu_write(16'h3001, 8'hC3);
      @(negedge clk_sys);
      ioctl_index = 8'd1; ioctl_download = 1'b1;
      @(negedge clk_sys); #1;
      vectors++; if (dl_err !== 1'b0 || cpu_hold !== 1'b1)
         begin miscompares++; $display("FAIL rst_load_entry got err=%b hold=%b want 0 1", dl_err, cpu_hold); end
      cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h9000;
      ioctl_wr = 1'b1; ioctl_addr = 25'h3000; ioctl_dout = 8'h55;
      @(negedge clk_sys);
      ioctl_addr = 25'h3001;
      @(negedge clk_sys);
      ioctl_wr = 1'b0; cpu_cs = 1'b0; ioctl_download = 1'b0; reset_n = 1'b0; #1;
      vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL rst_ram_en_in_reset got %b want 0", ram_en); end
      @(negedge clk_sys);
      reset_n = 1'b1; #1;
      vectors++; if ({cpu_hold, dl_done, dl_err, cpu_rvalid, ioctl_wait, ram_en} !== 6'b0)
         begin miscompares++; $display("FAIL rst_outputs got hold=%b done=%b err=%b rvalid=%b wait=%b en=%b want all 0",
                                       cpu_hold, dl_done, dl_err, cpu_rvalid, ioctl_wait, ram_en); end
      writes = ram_writes;
      repeat (8) @(negedge clk_sys);
      vectors++; if (ram_writes != writes) begin miscompares++; $display("FAIL rst_no_writes got %0d want 0", ram_writes - writes); end
      vectors++; if (mem[16'h3000] !== 8'hC3 || mem[16'h3001] !== 8'hC3)
         begin miscompares++; $display("FAIL rst_ram got %h %h want c3 c3", mem[16'h3000], mem[16'h3001]); end
      $display("reset_mid_load: buffered bytes abandoned");
   endtask

   initial begin
      test_reset();
      test_cpu_only();
      test_download();
      test_starve();
      test_back_to_back();
      test_bad_index();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
